// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the EX-stage branch resolver.
package branch_resolver_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_SQUASH = 1'b1
    } br_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] branch_pc;
        logic            predict;
        logic            actual;
        logic            branch;
    } res_pkt_t;

endpackage

// File: rtl/branch_resolver_if.sv
// EX-side operands in, resolution packet / squash / perf counters out.
interface branch_resolver_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic              stall;
    logic              ex_valid;
    logic              branch;
    logic              predict;
    logic              ujtype;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;

    logic [DATA_W-1:0] old_pc;
    logic [DATA_W-1:0] old_branch_pc;
    logic              old_predict;
    logic              old_actual;
    logic              old_branch;
    logic              redirect;
    logic              squash;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output stall, ex_valid, branch, predict, ujtype, funct3,
               rs1_data, rs2_data, pc, imm, pred_taken, pred_target,
        input  old_pc, old_branch_pc, old_predict, old_actual, old_branch,
               redirect, squash, branch_cnt, miss_cnt
    );

    modport slave (
        input  stall, ex_valid, branch, predict, ujtype, funct3,
               rs1_data, rs2_data, pc, imm, pred_taken, pred_target,
        output old_pc, old_branch_pc, old_predict, old_actual, old_branch,
               redirect, squash, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_compare.sv
// Conditional-branch comparator: funct3 selects the compare, unknown codes are not taken.
module branch_compare
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN
) (
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic              taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (funct3)
            BR_EQ:   taken_c = (rs1 == rs2);
            BR_NE:   taken_c = (rs1 != rs2);
            BR_LT:   taken_c = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken_c = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken_c = (rs1 <  rs2);
            BR_GEU:  taken_c = (rs1 >= rs2);
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves control transfers in EX, registers the predictor-update packet,
// squashes wrong-path instructions after a redirect and counts branches/misses.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DATA_W       = XLEN,
    parameter int unsigned SQUASH_DEPTH = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave br
);

    localparam int unsigned SQ_W = $clog2(SQUASH_DEPTH + 1);

    br_state_e         state, state_n;
    logic [SQ_W-1:0]   sq_cnt, sq_cnt_n;
    logic              squash_c;
    logic              taken_c;
    logic              res_en_c;
    res_pkt_t          pkt_d, pkt_q;
    logic              redirect_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;
    logic [DATA_W-1:0] seq_pc_c;
    logic [DATA_W-1:0] rel_pc_c;
    logic [DATA_W-1:0] jalr_pc_c;
    logic [DATA_W-1:0] next_pc_c;

    branch_compare #(.DATA_W(DATA_W)) u_cmp (
        .funct3  (br.funct3),
        .rs1     (br.rs1_data),
        .rs2     (br.rs2_data),
        .taken_c (taken_c)
    );

    assign res_en_c = br.ex_valid && br.branch && !squash_c && !br.stall;

    // Direction/target evaluation; jalr reports a RAS miss as predict=0/actual=1.
    always_comb begin
        seq_pc_c  = br.pc + DATA_W'(4);
        rel_pc_c  = br.pc + br.imm;
        jalr_pc_c = (br.rs1_data + br.imm) & {{(DATA_W-1){1'b1}}, 1'b0};
        next_pc_c = seq_pc_c;
        pkt_d     = '0;
        if (br.predict) begin
            next_pc_c     = taken_c ? rel_pc_c : seq_pc_c;
            pkt_d.predict = br.pred_taken;
            pkt_d.actual  = taken_c;
            pkt_d.branch  = 1'b1;
        end else if (br.ujtype) begin
            next_pc_c     = rel_pc_c;
            pkt_d.predict = 1'b1;
            pkt_d.actual  = 1'b1;
        end else begin
            next_pc_c     = jalr_pc_c;
            pkt_d.predict = (jalr_pc_c == br.pred_target);
            pkt_d.actual  = 1'b1;
        end
        pkt_d.pc        = XLEN'(next_pc_c);
        pkt_d.branch_pc = XLEN'(br.pc);
    end

    // Packet register: pulses clear on idle cycles, pcs hold, stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q      <= '0;
            redirect_q <= 1'b0;
        end else if (!br.stall) begin
            if (res_en_c) begin
                pkt_q      <= pkt_d;
                redirect_q <= (pkt_d.predict != pkt_d.actual);
            end else begin
                pkt_q.predict <= 1'b0;
                pkt_q.actual  <= 1'b0;
                pkt_q.branch  <= 1'b0;
                redirect_q    <= 1'b0;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (res_en_c) begin
            if (branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if ((pkt_d.predict != pkt_d.actual) && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_n;
            sq_cnt <= sq_cnt_n;
        end
    end

    // A fresh redirect (re)arms the squash window; bubbles do not consume it.
    always_comb begin
        state_n  = state;
        sq_cnt_n = sq_cnt;
        if (!br.stall) begin
            if (redirect_q) begin
                state_n  = S_SQUASH;
                sq_cnt_n = SQ_W'(SQUASH_DEPTH);
            end else if ((state == S_SQUASH) && br.ex_valid) begin
                sq_cnt_n = sq_cnt - SQ_W'(1);
                if (sq_cnt == SQ_W'(1))
                    state_n = S_RUN;
            end
        end
    end

    always_comb begin
        squash_c = 1'b0;
        if (state == S_SQUASH)
            squash_c = br.ex_valid;
    end

    assign br.squash        = squash_c;
    assign br.old_pc        = DATA_W'(pkt_q.pc);
    assign br.old_branch_pc = DATA_W'(pkt_q.branch_pc);
    assign br.old_predict   = pkt_q.predict;
    assign br.old_actual    = pkt_q.actual;
    assign br.old_branch    = pkt_q.branch;
    assign br.redirect      = redirect_q;
    assign br.branch_cnt    = branch_cnt_q;
    assign br.miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, table-driven bench for branch_resolver plus squash/stall/saturation/reset sequences.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolver_if #(.DATA_W(DW), .CNT_W(DW)) bif ();

    branch_resolver #(.DATA_W(DW), .SQUASH_DEPTH(2), .CNT_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .br  (bif)
    );

    typedef struct {
        logic        predict;
        logic        ujtype;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] e_pc;
        logic        e_pred;
        logic        e_act;
        logic        e_br;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_b   = 0;
    logic [31:0] exp_m   = 0;
    vec_t        vecs[14];

    function automatic vec_t mk(input logic p, input logic u, input logic [2:0] f3,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic pt, input logic [31:0] ptgt,
                                input logic [31:0] e_pc, input logic e_pred,
                                input logic e_act, input logic e_br);
        vec_t v;
        v.predict = p;   v.ujtype = u;  v.f3 = f3;  v.rs1 = rs1;   v.rs2 = rs2;
        v.pc = pc;       v.imm = imm;   v.pt = pt;  v.ptgt = ptgt;
        v.e_pc = e_pc;   v.e_pred = e_pred;  v.e_act = e_act;  v.e_br = e_br;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bif.stall = 0;       bif.ex_valid = 0;    bif.branch = 0;
        bif.predict = 0;     bif.ujtype = 0;      bif.funct3 = 3'b000;
        bif.rs1_data = 0;    bif.rs2_data = 0;    bif.pc = 0;
        bif.imm = 0;         bif.pred_taken = 0;  bif.pred_target = 0;
    endtask

    task automatic filler();
        idle();
        bif.ex_valid = 1;
    endtask

    task automatic apply(input vec_t v);
        bif.stall = 0;          bif.ex_valid = 1;        bif.branch = 1;
        bif.predict = v.predict; bif.ujtype = v.ujtype;  bif.funct3 = v.f3;
        bif.rs1_data = v.rs1;   bif.rs2_data = v.rs2;    bif.pc = v.pc;
        bif.imm = v.imm;        bif.pred_taken = v.pt;   bif.pred_target = v.ptgt;
    endtask

    task automatic chk_pkt(input string tag, input vec_t v);
        chk({tag, ".old_pc"},        bif.old_pc,        v.e_pc);
        chk({tag, ".old_branch_pc"}, bif.old_branch_pc, v.pc);
        chk({tag, ".old_predict"},   32'(bif.old_predict), 32'(v.e_pred));
        chk({tag, ".old_actual"},    32'(bif.old_actual),  32'(v.e_act));
        chk({tag, ".old_branch"},    32'(bif.old_branch),  32'(v.e_br));
        chk({tag, ".redirect"},      32'(bif.redirect),    32'(v.e_pred != v.e_act));
        chk({tag, ".branch_cnt"},    bif.branch_cnt, exp_b);
        chk({tag, ".miss_cnt"},      bif.miss_cnt,   exp_m);
    endtask

    task automatic resolve(input vec_t v);
        exp_b = exp_b + 1;
        if (v.e_pred != v.e_act && exp_m != 32'hFFFF_FFFF)
            exp_m = exp_m + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //                p  u  f3      rs1           rs2           pc            imm           pt ptgt        e_pc          ep ea eb
        vecs[0]  = mk(1, 0, BR_EQ,  32'h5,        32'h5,        32'h100,      32'h20,       0, 32'h0,      32'h120,      0, 1, 1);
        vecs[1]  = mk(1, 0, BR_LT,  32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1, 32'h240,    32'h240,      1, 1, 1);
        vecs[2]  = mk(1, 0, BR_LTU, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1, 32'h240,    32'h204,      1, 0, 1);
        vecs[3]  = mk(1, 0, BR_NE,  32'h3,        32'h3,        32'h300,      32'h10,       0, 32'h0,      32'h304,      0, 0, 1);
        vecs[4]  = mk(1, 0, BR_GE,  32'h1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF0, 0, 32'h0,      32'h3F0,      0, 1, 1);
        vecs[5]  = mk(1, 0, BR_GEU, 32'h1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF0, 0, 32'h0,      32'h404,      0, 0, 1);
        vecs[6]  = mk(1, 0, 3'b010, 32'h7,        32'h7,        32'h500,      32'h8,        1, 32'h508,    32'h504,      1, 0, 1);
        vecs[7]  = mk(1, 0, BR_EQ,  32'h0,        32'h0,        32'hFFFFFFF0, 32'h20,       1, 32'h10,     32'h10,       1, 1, 1);
        vecs[8]  = mk(1, 0, BR_NE,  32'h9,        32'h9,        32'hFFFFFFFC, 32'h40,       0, 32'h0,      32'h0,        0, 0, 1);
        vecs[9]  = mk(0, 1, BR_EQ,  32'h0,        32'h0,        32'h600,      32'h100,      1, 32'h700,    32'h700,      1, 1, 0);
        vecs[10] = mk(0, 0, BR_EQ,  32'h203,      32'h0,        32'h1000,     32'h0,        1, 32'h400,    32'h202,      0, 1, 0);
        vecs[11] = mk(0, 0, BR_EQ,  32'h1FF,      32'h0,        32'h1000,     32'h3,        1, 32'h202,    32'h202,      1, 1, 0);
        vecs[12] = mk(1, 0, BR_LTU, 32'h1,        32'h2,        32'h800,      32'h8,        1, 32'h808,    32'h808,      1, 1, 1);
        vecs[13] = mk(0, 0, BR_EQ,  32'h100,      32'h0,        32'h1100,     32'h11,       1, 32'h110,    32'h110,      1, 1, 0);

        // Reset state
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst.old_pc",        bif.old_pc, 0);
        chk("rst.old_branch_pc", bif.old_branch_pc, 0);
        chk("rst.old_branch",    32'(bif.old_branch), 0);
        chk("rst.old_predict",   32'(bif.old_predict), 0);
        chk("rst.old_actual",    32'(bif.old_actual), 0);
        chk("rst.redirect",      32'(bif.redirect), 0);
        chk("rst.squash",        32'(bif.squash), 0);
        chk("rst.branch_cnt",    bif.branch_cnt, 0);
        chk("rst.miss_cnt",      bif.miss_cnt, 0);

        // Table: one resolution, then three valid non-branch instructions to drain any squash window
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            step();
            resolve(vecs[i]);
            chk_pkt($sformatf("vec%0d", i), vecs[i]);
            for (int k = 0; k < 3; k++) begin
                filler();
                #1;
                if (k >= 1)
                    chk($sformatf("vec%0d.squash%0d", i, k), 32'(bif.squash),
                        32'(vecs[i].e_pred != vecs[i].e_act));
                step();
            end
            chk($sformatf("vec%0d.hold_pc", i),   bif.old_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.idle_branch", i), 32'(bif.old_branch | bif.old_predict | bif.old_actual), 0);
        end

        // Squash window: bubble does not consume it; 3rd valid branch resolves
        idle();
        v = mk(1, 0, BR_EQ, 32'h5, 32'h5, 32'h900, 32'h20, 0, 32'h0, 32'h920, 0, 1, 1);
        apply(v);
        step();
        resolve(v);
        chk_pkt("sq.first", v);
        idle();
        step();
        v = mk(1, 0, BR_EQ, 32'h5, 32'h5, 32'h940, 32'h20, 0, 32'h0, 32'h960, 0, 1, 1);
        apply(v);
        #1 chk("sq.b1.squash", 32'(bif.squash), 1);
        step();
        chk("sq.b1.old_branch", 32'(bif.old_branch), 0);
        chk("sq.b1.redirect",   32'(bif.redirect), 0);
        bif.ex_valid = 0;
        #1 chk("sq.bubble.squash", 32'(bif.squash), 0);
        step();
        apply(v);
        #1 chk("sq.b2.squash", 32'(bif.squash), 1);
        step();
        chk("sq.b2.old_branch", 32'(bif.old_branch), 0);
        chk("sq.b2.branch_cnt", bif.branch_cnt, exp_b);
        v = mk(1, 0, BR_EQ, 32'h5, 32'h5, 32'h980, 32'h20, 1, 32'h9A0, 32'h9A0, 1, 1, 1);
        apply(v);
        #1 chk("sq.b3.squash", 32'(bif.squash), 0);
        step();
        resolve(v);
        chk_pkt("sq.b3", v);
        idle();
        step();

        // Stall: mispredict held in EX for 3 stalled cycles, one pulse after release
        v = mk(1, 0, BR_NE, 32'h1, 32'h2, 32'hA00, 32'h30, 0, 32'h0, 32'hA30, 0, 1, 1);
        apply(v);
        bif.stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d.redirect", k), 32'(bif.redirect), 0);
            chk($sformatf("stall%0d.branch_cnt", k), bif.branch_cnt, exp_b);
        end
        bif.stall = 0;
        step();
        resolve(v);
        chk_pkt("stall.release", v);
        idle();
        step();
        chk("stall.after.redirect",   32'(bif.redirect), 0);
        chk("stall.after.branch_cnt", bif.branch_cnt, exp_b);
        for (int k = 0; k < 3; k++) begin
            filler();
            step();
        end

        // miss_cnt saturation
        idle();
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.miss_cnt_q;
        exp_m = 32'hFFFF_FFFF;
        chk("sat.preload", bif.miss_cnt, exp_m);
        v = mk(1, 0, BR_EQ, 32'h5, 32'h6, 32'hB00, 32'h20, 1, 32'hB20, 32'hB04, 1, 0, 1);
        apply(v);
        step();
        resolve(v);
        chk_pkt("sat", v);

        // Reset in the middle of a squash window
        filler();
        step();
        filler();
        #1 chk("rstsq.pre.squash", 32'(bif.squash), 1);
        rst = 1;
        step();
        exp_b = 0;
        exp_m = 0;
        chk("rstsq.squash",     32'(bif.squash), 0);
        chk("rstsq.old_pc",     bif.old_pc, 0);
        chk("rstsq.old_bpc",    bif.old_branch_pc, 0);
        chk("rstsq.flags",      32'({bif.old_branch, bif.old_predict, bif.old_actual, bif.redirect}), 0);
        chk("rstsq.branch_cnt", bif.branch_cnt, 0);
        chk("rstsq.miss_cnt",   bif.miss_cnt, 0);
        rst = 0;
        v = mk(0, 1, BR_EQ, 32'h0, 32'h0, 32'hC00, 32'h40, 1, 32'hC40, 32'hC40, 1, 1, 0);
        apply(v);
        #1 chk("rstsq.post.squash", 32'(bif.squash), 0);
        step();
        resolve(v);
        chk_pkt("rstsq.post", v);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage partner of the branch predictor. Evaluates every control-transfer instruction once its operands are known.
- Computes the actual direction and target and compares them with what IF predicted.
- Returns a one-cycle registered resolution packet (old_pc, old_branch_pc, old_predict, old_actual, old_branch) that drives predictor table update and redirect/flush.
- Also squashes wrong-path instructions after a redirect and keeps saturating branch/mispredict performance counters.

Parameters:
- DATA_W, 32, datapath width (matches `DATA_WID).
- SQUASH_DEPTH, 2, number of younger valid instructions discarded after a redirect (IF+ID in flight).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall; freezes all state, outputs hold
- ex_valid  in  1  EX holds a real instruction this cycle
- branch  in  1  instruction is a control transfer (from Control via ID/EX)
- predict  in  1  conditional branch (1) vs jal/jalr (0)
- ujtype  in  1  jal (1) vs jalr (0); meaningful when branch=1, predict=0
- funct3  in  3  compare type for conditional branches
- rs1_data, rs2_data  in  DATA_W  forwarded operands
- pc, imm  in  DATA_W  instruction pc and immediate
- pred_taken  in  1  predict_result carried down the pipe
- pred_target  in  DATA_W  target_pc carried down the pipe
- old_pc  out  DATA_W  correct next pc
- old_branch_pc  out  DATA_W  pc of the resolved branch
- old_predict, old_actual  out  1  predicted/actual direction (redirect encoding below)
- old_branch  out  1  pulse: conditional branch resolved, update BHT
- redirect  out  1  pulse: equals old_predict != old_actual
- squash  out  1  combinational: current EX instruction is wrong-path
- branch_cnt, miss_cnt  out  CNT_W  resolved control transfers / redirects

Behaviour:
- Reset: all outputs, counters and the squash counter are 0; FSM in RUN.
- Resolution (combinational, then registered on posedge):
  - Resolution is enabled only when ex_valid && branch && !squash && !stall.
  - Conditional compare by funct3:
    - 000 eq, 001 ne
    - 100 signed lt, 101 signed ge
    - 110 unsigned lt, 111 unsigned ge
    - any other funct3: not taken
  - Conditional: actual = compare result; target = actual ? pc+imm : pc+4 (mod 2^DATA_W wrap). Output old_predict=pred_taken, old_actual=actual, old_branch=1.
  - jal: target = pc+imm; old_predict=old_actual=1; old_branch=0.
  - jalr: target = (rs1_data+imm) & ~1; old_branch=0.
    - If target != pred_target (RAS miss), output old_predict=0, old_actual=1, which forces a redirect.
    - Otherwise output 1/1.
  - Conditional predicted taken with correct direction but pred_target != pc+imm: not possible, so it is not checked.
- Output packet:
  - old_pc=target and old_branch_pc=pc are valid in the cycle after EX.
  - old_branch and redirect are one-cycle pulses.
  - In a cycle with no resolution: old_branch, old_predict and old_actual clear to 0; old_pc and old_branch_pc hold.
- Stall: the packet holds its previous value and is not re-pulsed.
- Squash FSM, states RUN and SQUASH, with counter sq_cnt of width clog2(SQUASH_DEPTH+1):
  - RUN -> SQUASH when the registered redirect is asserted; sq_cnt := SQUASH_DEPTH.
  - In SQUASH, squash=ex_valid. Each non-stalled cycle with ex_valid decrements sq_cnt. Bubbles (ex_valid=0) do not count.
  - SQUASH -> RUN when sq_cnt reaches 0 after a decrement.
  - Squashed branches produce no packet and no counter increment.
- Counters:
  - branch_cnt +1 per resolved control transfer.
  - miss_cnt +1 per redirect.
  - Both saturate at all-ones, no wrap.
  - If rst and an increment occur in the same cycle, reset wins.
- Reset mid-squash returns to RUN with sq_cnt=0.

Decomposition:
- Shared package / Const.svh:
  - funct3 encodings as BR_EQ..BR_GEU constants.
  - Resolver FSM state enum.
  - Resolution packet struct typedef (pc, branch_pc, predict, actual, branch).
- One sub-module, branch_compare: purely combinational funct3/rs1/rs2 -> taken. It is reused by the verification model.

Test Plan:
- Reset, then beq with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle old_actual=1, old_predict=0, old_pc=0x120, old_branch_pc=0x100, old_branch=1, redirect=1, miss_cnt=1.
- blt with rs1=0xFFFFFFFF, rs2=1 (signed -1<1) and pred_taken=1 -> actual 1, redirect=0. Same operands with bltu -> actual 0, old_pc=pc+4.
- jalr with rs1_data=0x203, imm=0, pred_target=0x400 -> old_pc=0x202, old_predict=0, old_actual=1, redirect=1, old_branch=0.
- Redirect followed by 3 valid branches with an ex_valid bubble between the first two -> first 2 valid branches squash=1 with no packet; the 3rd resolves; branch_cnt rises by exactly 1.
- stall held 3 cycles with a mispredicting branch in EX -> exactly one redirect pulse, after stall release.
- Preload miss_cnt to all-ones via force, then mispredict -> miss_cnt stays 0xFFFFFFFF. Assert rst mid-SQUASH -> squash=0 and all outputs 0 the next cycle.
